tfhe_rd_dma: RTL and testbench

- Read-DMA engine directly downstream of the host control-register block.
- Consumes `start_pbs`, `host_wr_addr` and `host_wr_len`, and fetches the input ciphertext from host memory over an AXI4 master read channel.
- Streams the data to the PBS core over AXI4-Stream.
- Drives `pbs_busy` and `pbs_done` back to the control block, and reports progress on `host_rd_addr` and `host_rd_len`.

---
 rtl/tfhe_dma_pkg.sv | 31 +++
 rtl/tfhe_axis_skid.sv | 47 ++++
 rtl/tfhe_rd_dma.sv | 148 ++++++++++++++
 tb/tb_tfhe_rd_dma.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tfhe_dma_pkg.sv
// Shared definitions for the TFHE read-DMA: FSM encoding, AXI constants and
// the address-alignment helper.
package tfhe_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } dma_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam int unsigned BOUNDARY_4K   = 4096;
  localparam int unsigned BOUNDARY_BITS = 12;

  function automatic int unsigned bytes_log2(input int unsigned bytes);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < bytes) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tfhe_axis_skid.sv
// Two-entry skid buffer: registered outputs, one beat per cycle, and an
// input ready that depends only on local state.
module tfhe_axis_skid #(
  parameter int unsigned W = 73
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         empty
);

  logic [W-1:0] skid_data;
  logic         skid_valid;

  assign in_ready = ~skid_valid;
  assign empty    = ~out_valid & ~skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      // Output slot frees up: the parked beat has priority over the input.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/tfhe_rd_dma.sv
// Read-DMA: fetches a host buffer over AXI4 read bursts (4 KB safe, one burst
// outstanding) and forwards it to the PBS core as an AXI4-Stream.
module tfhe_rd_dma
  import tfhe_dma_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST          = 16
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              start_pbs,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     host_wr_addr,
  input  logic [31:0]                       host_wr_len,
  output logic                              pbs_busy,
  output logic                              pbs_done,
  output logic                              dma_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     host_rd_addr,
  output logic [31:0]                       host_rd_len,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic [2:0]                        M_AXI_ARSIZE,
  output logic [1:0]                        M_AXI_ARBURST,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY
);

  localparam int unsigned BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned LB    = bytes_log2(BYTES);
  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned SW    = C_M_AXI_DATA_WIDTH + BYTES + 1;

  dma_state_e        state;
  logic [32:0]       beats_rem;
  logic [32:0]       beats_4k;
  logic [32:0]       burst_sel;
  logic [8:0]        burst_q;
  logic [LB-1:0]     tail_q;
  logic              r_hs;
  logic              r_bad;
  logic              push_last;
  logic [BYTES-1:0]  tail_keep;
  logic [BYTES-1:0]  push_keep;
  logic              skid_ready;
  logic              skid_empty;
  logic [SW-1:0]     skid_out;

  assign M_AXI_ARSIZE  = 3'(LB);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_RREADY  = (state == ST_DATA) && skid_ready;

  assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
  assign r_bad     = (M_AXI_RRESP != RESP_OKAY);
  assign tail_keep = ~({BYTES{1'b1}} << tail_q);
  assign push_keep = (M_AXI_RLAST && beats_rem == '0 && tail_q != '0) ? tail_keep : '1;
  // An error cuts the transfer at the end of the failing burst, so that beat closes the packet.
  assign push_last = M_AXI_RLAST && (beats_rem == '0 || dma_err || r_bad);

  always_comb begin
    beats_4k  = 33'((BOUNDARY_4K - 32'(host_rd_addr[BOUNDARY_BITS-1:0])) >> LB);
    burst_sel = beats_rem;
    if (burst_sel > 33'(MAX_BURST)) burst_sel = 33'(MAX_BURST);
    if (burst_sel > beats_4k)       burst_sel = beats_4k;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= ST_IDLE;
      beats_rem     <= '0;
      burst_q       <= '0;
      tail_q        <= '0;
      pbs_busy      <= 1'b0;
      pbs_done      <= 1'b0;
      dma_err       <= 1'b0;
      host_rd_addr  <= '0;
      host_rd_len   <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARVALID <= 1'b0;
    end else begin
      if (M_AXIS_TVALID && M_AXIS_TREADY)
        host_rd_len <= host_rd_len + ((M_AXIS_TKEEP == '1) ? 32'(BYTES) : 32'(tail_q));
      case (state)
        ST_IDLE: if (start_pbs) begin
          host_rd_addr <= host_wr_addr & ~AW'(BYTES - 1);
          beats_rem    <= ({1'b0, host_wr_len} + 33'(BYTES - 1)) >> LB;
          tail_q       <= host_wr_len[LB-1:0];
          pbs_done     <= 1'b0;
          dma_err      <= 1'b0;
          host_rd_len  <= '0;
          pbs_busy     <= 1'b1;
          state        <= (host_wr_len == '0) ? ST_DONE : ST_CALC;
        end
        ST_CALC: begin
          M_AXI_ARADDR  <= host_rd_addr;
          M_AXI_ARLEN   <= 8'(burst_sel - 33'd1);
          burst_q       <= 9'(burst_sel);
          M_AXI_ARVALID <= 1'b1;
          state         <= ST_ADDR;
        end
        ST_ADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          host_rd_addr  <= host_rd_addr + (AW'(burst_q) << LB);
          beats_rem     <= beats_rem - 33'(burst_q);
          state         <= ST_DATA;
        end
        ST_DATA: if (r_hs) begin
          if (r_bad) dma_err <= 1'b1;
          if (M_AXI_RLAST)
            state <= (beats_rem == '0 || dma_err || r_bad) ? ST_DONE : ST_CALC;
        end
        ST_DONE: if (skid_empty) begin
          pbs_busy <= 1'b0;
          pbs_done <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tfhe_axis_skid #(
    .W(SW)
  ) u_skid (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARESET),
    .in_data   ({M_AXI_RDATA, push_keep, push_last}),
    .in_valid  (M_AXI_RVALID && (state == ST_DATA)),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (M_AXIS_TVALID),
    .out_ready (M_AXIS_TREADY),
    .empty     (skid_empty)
  );

  assign {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} = skid_out;

endmodule

// File: tb/tb_tfhe_rd_dma.sv
// Directed bench for tfhe_rd_dma with a one-burst AXI read slave and a stream sink.
module tb_tfhe_rd_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pbs;
  logic [31:0] host_wr_addr, host_wr_len;
  logic        pbs_busy, pbs_done, dma_err;
  logic [31:0] host_rd_addr, host_rd_len;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [63:0] M_AXIS_TDATA;
  logic [7:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [63:0] rx_data_q[$];
  logic [7:0]  rx_keep_q[$];
  logic        rx_last_q[$];
  bit          arvalid_seen;
  bit          gap_mode;
  bit          tready_rand;
  int          err_beat;
  int          slv_gbeat;

  always #5 clk = ~clk;

  tfhe_rd_dma #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(64),
    .MAX_BURST(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .start_pbs(start_pbs), .host_wr_addr(host_wr_addr), .host_wr_len(host_wr_len),
    .pbs_busy(pbs_busy), .pbs_done(pbs_done), .dma_err(dma_err),
    .host_rd_addr(host_rd_addr), .host_rd_len(host_rd_len),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // AXI read slave: handshakes sampled at negedge, new values driven 1 after posedge.
  initial begin : slave
    logic        ar_hs, r_hs;
    logic [31:0] cap_addr, cur;
    logic [7:0]  cap_len;
    int          left;
    M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
    left = 0; cur = '0; cap_addr = '0; cap_len = '0;
    forever begin
      @(negedge clk);
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      if (M_AXI_ARVALID) arvalid_seen = 1'b1;
      if (ar_hs) begin
        cap_addr = M_AXI_ARADDR; cap_len = M_AXI_ARLEN;
        ar_addr_q.push_back(cap_addr); ar_len_q.push_back(cap_len);
      end
      @(posedge clk); #1;
      if (rst) begin
        left = 0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
      end else begin
        if (ar_hs) begin cur = cap_addr; left = int'(cap_len) + 1; end
        if (r_hs) begin left--; cur += 32'd8; slv_gbeat++; end
        if (!(M_AXI_RVALID && !r_hs)) begin
          if (left > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = mem_word(cur);
            M_AXI_RRESP  = (slv_gbeat == err_beat) ? 2'b10 : 2'b00;
            M_AXI_RLAST  = (left == 1);
          end else begin
            M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
          end
        end
      end
    end
  end

  // Stream sink: logs accepted beats and checks that stalled beats hold steady.
  initial begin : sink
    logic        stalled;
    logic [72:0] held;
    M_AXIS_TREADY = 1'b0; stalled = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) begin
          n_tests++;
          assert (M_AXIS_TVALID && {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} === held) else begin
            n_fail++;
            $error("FAIL stall_hold: observed v=%0b %0h expected v=1 %0h", M_AXIS_TVALID,
                   {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST}, held);
          end
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          rx_data_q.push_back(M_AXIS_TDATA); rx_keep_q.push_back(M_AXIS_TKEEP);
          rx_last_q.push_back(M_AXIS_TLAST);
        end
        stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
        held    = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST};
      end
      @(posedge clk); #1;
      M_AXIS_TREADY = tready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete();
    rx_data_q.delete(); rx_keep_q.delete(); rx_last_q.delete();
    arvalid_seen = 1'b0; slv_gbeat = 0;
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
    host_wr_addr = a; host_wr_len = l; start_pbs = 1'b1;
    @(posedge clk); #1;
    start_pbs = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!(pbs_done && !pbs_busy) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done"}, 64'(pbs_done), 64'd1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base,
                              input int unsigned len, input int nbeats);
    int unsigned total;
    logic [7:0]  ek;
    total = (len + 7) / 8;
    chk({tag, " nbeats"}, 64'(rx_data_q.size()), 64'(nbeats));
    for (int i = 0; i < nbeats && i < rx_data_q.size(); i++) begin
      ek = 8'hFF;
      if (i == int'(total) - 1 && len % 8 != 0) ek = 8'hFF >> (8 - len % 8);
      chk($sformatf("%s data%0d", tag, i), rx_data_q[i], mem_word(base + 32'(8 * i)));
      chk($sformatf("%s keep%0d", tag, i), 64'(rx_keep_q[i]), 64'(ek));
      chk($sformatf("%s last%0d", tag, i), 64'(rx_last_q[i]), 64'(i == nbeats - 1));
    end
  endtask

  task automatic check_ar(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
    if (idx < ar_addr_q.size()) begin
      chk($sformatf("%s araddr%0d", tag, idx), 64'(ar_addr_q[idx]), 64'(a));
      chk($sformatf("%s arlen%0d", tag, idx), 64'(ar_len_q[idx]), 64'(l));
    end else begin
      chk($sformatf("%s ar%0d present", tag, idx), 64'(ar_addr_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin : main
    rst = 1'b1; start_pbs = 1'b0; host_wr_addr = '0; host_wr_len = '0;
    gap_mode = 1'b0; tready_rand = 1'b0; err_beat = -1; slv_gbeat = 0; arvalid_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(pbs_busy), 64'd0);
    chk("rst done", 64'(pbs_done), 64'd0);
    chk("rst err", 64'(dma_err), 64'd0);
    chk("rst arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("rst rready", 64'(M_AXI_RREADY), 64'd0);
    chk("rst tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst arsize", 64'(M_AXI_ARSIZE), 64'd3);
    chk("rst arburst", 64'(M_AXI_ARBURST), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // aligned single burst
    clear_logs(); start_xfer(32'h1000, 32'd64); wait_done("t1");
    chk("t1 ar count", 64'(ar_addr_q.size()), 64'd1);
    check_ar("t1", 0, 32'h1000, 8'd7);
    check_stream("t1", 32'h1000, 64, 8);
    chk("t1 rd_len", 64'(host_rd_len), 64'd64);
    chk("t1 rd_addr", 64'(host_rd_addr), 64'h1040);

    // 4 KB boundary split
    clear_logs(); start_xfer(32'h0FF0, 32'd64); wait_done("t2");
    chk("t2 ar count", 64'(ar_addr_q.size()), 64'd2);
    check_ar("t2", 0, 32'h0FF0, 8'd1);
    check_ar("t2", 1, 32'h1000, 8'd5);
    check_stream("t2", 32'h0FF0, 64, 8);
    chk("t2 rd_addr", 64'(host_rd_addr), 64'h1030);

    // MAX_BURST split, plus an ignored start while busy
    clear_logs(); start_xfer(32'h0, 32'd200);
    repeat (5) @(posedge clk);
    #1;
    start_xfer(32'h8000, 32'd8);
    wait_done("t3");
    chk("t3 ar count", 64'(ar_addr_q.size()), 64'd2);
    check_ar("t3", 0, 32'h0, 8'd15);
    check_ar("t3", 1, 32'h80, 8'd8);
    check_stream("t3", 32'h0, 200, 25);
    chk("t3 rd_len", 64'(host_rd_len), 64'd200);
    chk("t3 rd_addr", 64'(host_rd_addr), 64'hC8);

    // partial final beat
    clear_logs(); start_xfer(32'h100, 32'd203); wait_done("t3b");
    chk("t3b ar count", 64'(ar_addr_q.size()), 64'd2);
    check_ar("t3b", 1, 32'h180, 8'd9);
    check_stream("t3b", 32'h100, 203, 26);
    chk("t3b rd_len", 64'(host_rd_len), 64'd203);
    chk("t3b rd_addr", 64'(host_rd_addr), 64'h1D0);

    // zero length
    clear_logs(); start_xfer(32'h2000, 32'd0);
    chk("t4 busy", 64'(pbs_busy), 64'd1);
    chk("t4 done cleared", 64'(pbs_done), 64'd0);
    @(posedge clk); #1;
    chk("t4 done", 64'(pbs_done), 64'd1);
    chk("t4 busy end", 64'(pbs_busy), 64'd0);
    chk("t4 no arvalid", 64'(arvalid_seen), 64'd0);
    chk("t4 rd_len", 64'(host_rd_len), 64'd0);
    chk("t4 nbeats", 64'(rx_data_q.size()), 64'd0);

    // error response on beat 3 of the first burst
    clear_logs(); err_beat = 2; start_xfer(32'h0FC0, 32'd128); wait_done("t5");
    repeat (4) @(posedge clk);
    #1;
    err_beat = -1;
    chk("t5 ar count", 64'(ar_addr_q.size()), 64'd1);
    check_ar("t5", 0, 32'h0FC0, 8'd7);
    check_stream("t5", 32'h0FC0, 128, 8);
    chk("t5 err", 64'(dma_err), 64'd1);
    chk("t5 rd_len", 64'(host_rd_len), 64'd64);

    // backpressure and R gaps, unaligned start address
    gap_mode = 1'b1; tready_rand = 1'b1;
    clear_logs(); start_xfer(32'h300B, 32'd301); wait_done("t6");
    chk("t6 ar count", 64'(ar_addr_q.size()), 64'd3);
    check_ar("t6", 2, 32'h3108, 8'd5);
    check_stream("t6", 32'h3008, 301, 38);
    chk("t6 rd_len", 64'(host_rd_len), 64'd301);
    chk("t6 rd_addr", 64'(host_rd_addr), 64'h3138);
    chk("t6 err", 64'(dma_err), 64'd0);

    // reset mid-burst
    clear_logs(); start_xfer(32'h4000, 32'd256);
    repeat (12) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rst2 busy", 64'(pbs_busy), 64'd0);
    chk("rst2 arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("rst2 araddr", 64'(M_AXI_ARADDR), 64'd0);
    chk("rst2 rready", 64'(M_AXI_RREADY), 64'd0);
    chk("rst2 tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst2 tdata", M_AXIS_TDATA, 64'd0);
    chk("rst2 rd_len", 64'(host_rd_len), 64'd0);
    chk("rst2 rd_addr", 64'(host_rd_addr), 64'd0);
    @(posedge clk); #1;
    chk("rst2 busy held", 64'(pbs_busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    gap_mode = 1'b0; tready_rand = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_logs(); start_xfer(32'h5000, 32'd64); wait_done("t7");
    chk("t7 ar count", 64'(ar_addr_q.size()), 64'd1);
    check_ar("t7", 0, 32'h5000, 8'd7);
    check_stream("t7", 32'h5000, 64, 8);
    chk("t7 rd_len", 64'(host_rd_len), 64'd64);
    chk("t7 err", 64'(dma_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
